// File: rtl/tl_a_arbiter.sv
// TileLink A-channel arbiter: round-robin N:1 pass-through with burst lock.
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  per-requester A-channel handshake
//   in_opcode/param/size/source/address/data  packed per-requester fields
//   out_valid/out_ready and out_* fields       to downstream enqueue port
//   out_grant          index of the requester currently granted
//   size_err           sticky: a first beat with size > MAX_SIZE was accepted
module tl_a_arbiter #(
    parameter int N          = 4,
    parameter int BEAT_SHIFT = 3,
    parameter int MAX_SIZE   = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic [3*N-1:0]    in_opcode,
    input  logic [3*N-1:0]    in_param,
    input  logic [4*N-1:0]    in_size,
    input  logic [2*N-1:0]    in_source,
    input  logic [32*N-1:0]   in_address,
    input  logic [64*N-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_opcode,
    output logic [2:0]        out_param,
    output logic [3:0]        out_size,
    output logic [3:0]        out_source,
    output logic [31:0]       out_address,
    output logic [63:0]       out_data,
    output logic [1:0]        out_grant,
    output logic              size_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] BURST = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] rr_q, rr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] grant_q, grant_d;
    logic       size_err_q, size_err_d;

    logic [1:0] sel;
    logic       found;
    logic [2:0] idx;
    logic [1:0] grant;
    logic [1:0] g_source;
    logic       fire;
    logic [3:0] size_clip;
    logic [3:0] shamt;
    logic [4:0] beats;
    logic [2:0] cnt_init;
    logic       multi;
    logic [1:0] rr_next;

    // Rotating priority search starting at rr, wrapping modulo N.
    always_comb begin
        sel   = rr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, rr_q} + 3'(k);
            if (idx >= 3'(N)) idx = idx - 3'(N);
            for (int i = 0; i < N; i++) begin
                if (!found && idx == 3'(i) && in_valid[i]) begin
                    sel   = 2'(i);
                    found = 1'b1;
                end
            end
        end
    end

    assign grant = (state_q == IDLE) ? sel : grant_q;

    always_comb begin
        out_valid   = 1'b0;
        out_opcode  = '0;
        out_param   = '0;
        out_size    = '0;
        g_source    = '0;
        out_address = '0;
        out_data    = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == 2'(i)) begin
                out_valid   = in_valid[i];
                out_opcode  = in_opcode[3*i +: 3];
                out_param   = in_param[3*i +: 3];
                out_size    = in_size[4*i +: 4];
                g_source    = in_source[2*i +: 2];
                out_address = in_address[32*i +: 32];
                out_data    = in_data[64*i +: 64];
            end
        end
    end

    // Locked (non-IDLE) states hand ready to the owner even while it idles.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = out_ready && (grant == 2'(i)) &&
                          ((state_q != IDLE) || in_valid[i]);
        end
    end

    assign out_source = {grant, g_source};
    assign out_grant  = grant;
    assign size_err   = size_err_q;
    assign fire       = out_valid && out_ready;

    // Beat count of the message offered on its first beat.
    assign size_clip = (out_size > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : out_size;
    assign multi     = (out_opcode == 3'd0 || out_opcode == 3'd1) &&
                       (size_clip > 4'(BEAT_SHIFT));
    assign shamt     = size_clip - 4'(BEAT_SHIFT);
    assign beats     = 5'd1 << shamt;
    assign cnt_init  = 3'(beats - 5'd2);
    assign rr_next   = (grant == 2'(N-1)) ? 2'd0 : grant + 2'd1;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        size_err_d = size_err_q;
        case (state_q)
            IDLE, HOLD: begin
                if (fire) begin
                    grant_d    = grant;
                    size_err_d = size_err_q || (out_size > 4'(MAX_SIZE));
                    if (multi) begin
                        state_d = BURST;
                        cnt_d   = cnt_init;
                    end else begin
                        state_d = IDLE;
                        rr_d    = rr_next;
                    end
                end else if (out_valid) begin
                    state_d = HOLD;
                    grant_d = grant;
                end
            end
            BURST: begin
                if (fire) begin
                    if (cnt_q == 3'd0) begin
                        state_d = IDLE;
                        rr_d    = rr_next;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            size_err_q <= size_err_d;
        end
    end

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Directed bench for tl_a_arbiter: vector table for arbitration/handshake,
// hand sequences for bursts, size clipping and reset abort.
module tb_tl_a_arbiter;

    localparam int N = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [3*N-1:0]  in_opcode;
    logic [3*N-1:0]  in_param;
    logic [4*N-1:0]  in_size;
    logic [2*N-1:0]  in_source;
    logic [32*N-1:0] in_address;
    logic [64*N-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_opcode;
    logic [2:0]      out_param;
    logic [3:0]      out_size;
    logic [3:0]      out_source;
    logic [31:0]     out_address;
    logic [63:0]     out_data;
    logic [1:0]      out_grant;
    logic            size_err;

    tl_a_arbiter #(.N(N), .BEAT_SHIFT(3), .MAX_SIZE(6)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_param(in_param),
        .in_size(in_size), .in_source(in_source),
        .in_address(in_address), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_param(out_param),
        .out_size(out_size), .out_source(out_source),
        .out_address(out_address), .out_data(out_data),
        .out_grant(out_grant), .size_err(size_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [3:0] v;
        logic       ordy;
        logic [1:0] g;
        logic       ov;
        logic [3:0] ir;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op,
                           input logic [3:0] sz, input logic [1:0] src);
        in_opcode[3*i +: 3] = op;
        in_size[4*i +: 4]   = sz;
        in_source[2*i +: 2] = src;
    endtask

    task automatic all_get();
        for (int i = 0; i < N; i++) set_req(i, 3'd4, 4'd3, 2'(i));
    endtask

    task automatic do_reset();
        in_valid  = '0;
        out_ready = 1'b1;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
        all_get();
    endtask

    task automatic chk_beat(input string nm, input logic [1:0] g,
                            input logic [3:0] ir);
        chk({nm, "_grant"}, 32'(out_grant), 32'(g));
        chk({nm, "_ovalid"}, 32'(out_valid), 32'd1);
        chk({nm, "_iready"}, 32'(in_ready), 32'(ir));
    endtask

    initial begin
        tbl[0]  = '{4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0101, 1'b1, 2'd0, 1'b1, 4'b0001};
        tbl[2]  = '{4'b0101, 1'b1, 2'd2, 1'b1, 4'b0100};
        tbl[3]  = '{4'b0101, 1'b1, 2'd0, 1'b1, 4'b0001};
        tbl[4]  = '{4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000};
        tbl[5]  = '{4'b1000, 1'b0, 2'd3, 1'b1, 4'b0000};
        tbl[6]  = '{4'b1001, 1'b0, 2'd3, 1'b1, 4'b0000};
        tbl[7]  = '{4'b1001, 1'b0, 2'd3, 1'b1, 4'b0000};
        tbl[8]  = '{4'b1001, 1'b1, 2'd3, 1'b1, 4'b1000};
        tbl[9]  = '{4'b1001, 1'b1, 2'd0, 1'b1, 4'b0001};
        tbl[10] = '{4'b0010, 1'b0, 2'd1, 1'b1, 4'b0000};
        tbl[11] = '{4'b0000, 1'b1, 2'd1, 1'b0, 4'b0010};
        tbl[12] = '{4'b0010, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[13] = '{4'b0011, 1'b1, 2'd0, 1'b1, 4'b0001};

        in_param = '0;
        for (int i = 0; i < N; i++) begin
            in_address[32*i +: 32] = 32'h1000_0000 + 32'(i);
            in_data[64*i +: 64]    = 64'hABCD_0000_0000_0000 + 64'(i);
        end
        do_reset();
        chk("reset_size_err", 32'(size_err), 32'd0);

        // Single-beat arbitration, HOLD and handshake table.
        for (int t = 0; t < 14; t++) begin
            in_valid  = tbl[t].v;
            out_ready = tbl[t].ordy;
            #1;
            chk($sformatf("v%0d_grant", t), 32'(out_grant), 32'(tbl[t].g));
            chk($sformatf("v%0d_ovalid", t), 32'(out_valid), 32'(tbl[t].ov));
            chk($sformatf("v%0d_iready", t), 32'(in_ready), 32'(tbl[t].ir));
            if (tbl[t].ov) begin
                chk($sformatf("v%0d_addr", t), out_address,
                    32'h1000_0000 + 32'(tbl[t].g));
                chk($sformatf("v%0d_src", t), 32'(out_source),
                    32'({tbl[t].g, tbl[t].g}));
            end
            step();
        end

        // 8-beat PutFull from requester 1 with mid-burst valid drop.
        do_reset();
        in_valid = 4'b0001;
        #1;
        chk("pre_grant0", 32'(out_grant), 32'd0);
        step();
        set_req(1, 3'd0, 4'd6, 2'd1);
        in_valid = 4'b0011;
        for (int b = 0; b < 8; b++) begin
            if (b == 4) begin
                in_valid[1] = 1'b0;
                #1;
                chk("drop_ovalid", 32'(out_valid), 32'd0);
                chk("drop_grant", 32'(out_grant), 32'd1);
                step();
                in_valid[1] = 1'b1;
            end
            #1;
            chk_beat($sformatf("put8_b%0d", b), 2'd1, 4'b0010);
            step();
            if (b == 0) set_req(1, 3'd4, 4'd0, 2'd1);
        end
        #1;
        chk("put8_next_grant", 32'(out_grant), 32'd0);
        chk("put8_next_iready", 32'(in_ready), 32'b0001);
        chk("put8_size_err", 32'(size_err), 32'd0);

        // PutPartial size 7: clipped to 8 beats, size_err sticky.
        do_reset();
        set_req(2, 3'd1, 4'd7, 2'd0);
        in_valid = 4'b1100;
        for (int b = 0; b < 8; b++) begin
            #1;
            chk_beat($sformatf("pp7_b%0d", b), 2'd2, 4'b0100);
            step();
            if (b == 0) chk("pp7_err_set", 32'(size_err), 32'd1);
        end
        #1;
        chk("pp7_next_grant", 32'(out_grant), 32'd3);
        step();
        in_valid = '0;
        step();
        chk("pp7_err_sticky", 32'(size_err), 32'd1);
        do_reset();
        chk("pp7_err_clear", 32'(size_err), 32'd0);

        // Source ID widening.
        set_req(2, 3'd4, 4'd3, 2'd1);
        in_valid = 4'b0100;
        #1;
        chk("src_widen", 32'(out_source), 32'b1001);
        step();

        // Reset in the middle of an 8-beat burst.
        do_reset();
        set_req(2, 3'd0, 4'd6, 2'd0);
        in_valid = 4'b0100;
        for (int b = 0; b < 3; b++) begin
            #1;
            chk_beat($sformatf("abort_b%0d", b), 2'd2, 4'b0100);
            step();
        end
        reset    = 1'b1;
        in_valid = 4'b0010;
        step();
        reset = 1'b0;
        #1;
        chk_beat("abort_after", 2'd1, 4'b0010);
        step();

        // 2-beat Put (counter starts at 0) then 1-beat Put at size 3.
        do_reset();
        set_req(0, 3'd0, 4'd4, 2'd0);
        in_valid = 4'b0011;
        #1;
        chk_beat("put2_b0", 2'd0, 4'b0001);
        step();
        chk_beat("put2_b1", 2'd0, 4'b0001);
        step();
        chk_beat("put2_next", 2'd1, 4'b0010);
        step();
        set_req(0, 3'd0, 4'd3, 2'd0);
        #1;
        chk_beat("put1_b0", 2'd0, 4'b0001);
        step();
        chk_beat("put1_next", 2'd1, 4'b0010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
